// File: rtl/rfp_gpo_sequencer_if.sv
// Configuration write port for the GPO sequencer: one strobe writes the
// on/off delays and the polarity of a single line.
interface rfp_gpo_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int DLY_W  = 8
);
   logic              cfg_wr;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DLY_W-1:0]  cfg_on_dly;
   logic [DLY_W-1:0]  cfg_off_dly;
   logic              cfg_inv;

   modport master (output cfg_wr, cfg_addr, cfg_on_dly, cfg_off_dly, cfg_inv);
   modport slave  (input  cfg_wr, cfg_addr, cfg_on_dly, cfg_off_dly, cfg_inv);
endinterface

// File: rtl/rfp_gpo_sequencer.sv
// Per-line timing shaper for the RF front-end GPO pins: synchronise, apply
// programmable rise/fall delays with glitch suppression, optional inversion.
module rfp_gpo_seq_lane #(
   parameter int DLY_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             s2,
   input  logic             wr,
   input  logic [DLY_W-1:0] on_dly,
   input  logic [DLY_W-1:0] off_dly,
   input  logic             inv,
   output logic             line_out,
   output logic             busy
);
   typedef enum logic [1:0] {LOW, PEND_HIGH, HIGH, PEND_LOW} state_t;

   state_t           st, st_n;
   logic [DLY_W-1:0] cnt, cnt_n;
   logic [DLY_W-1:0] on_q, off_q;
   logic             inv_q;
   logic             lvl_n;

   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      if (!enable) begin
         st_n  = LOW;
         cnt_n = '0;
      end else begin
         case (st)
            LOW: if (s2) begin
               if (on_q == '0) st_n = HIGH;
               else begin cnt_n = on_q; st_n = PEND_HIGH; end
            end
            PEND_HIGH: begin
               if (!s2) begin st_n = LOW; cnt_n = '0; end
               else if (cnt == DLY_W'(1)) begin st_n = HIGH; cnt_n = '0; end
               else cnt_n = cnt - DLY_W'(1);
            end
            HIGH: if (!s2) begin
               if (off_q == '0) st_n = LOW;
               else begin cnt_n = off_q; st_n = PEND_LOW; end
            end
            PEND_LOW: begin
               if (s2) begin st_n = HIGH; cnt_n = '0; end
               else if (cnt == DLY_W'(1)) begin st_n = LOW; cnt_n = '0; end
               else cnt_n = cnt - DLY_W'(1);
            end
            default: begin st_n = LOW; cnt_n = '0; end
         endcase
      end
      lvl_n = (st_n == HIGH) || (st_n == PEND_LOW);
   end

   // Delay loads above read on_q/off_q before this edge's write lands.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st       <= LOW;
         cnt      <= '0;
         on_q     <= '0;
         off_q    <= '0;
         inv_q    <= 1'b0;
         line_out <= 1'b0;
         busy     <= 1'b0;
      end else begin
         st       <= st_n;
         cnt      <= cnt_n;
         line_out <= lvl_n ^ inv_q;
         busy     <= (st_n == PEND_HIGH) || (st_n == PEND_LOW);
         if (wr) begin
            on_q  <= on_dly;
            off_q <= off_dly;
            inv_q <= inv;
         end
      end
   end
endmodule

module rfp_gpo_sequencer #(
   parameter int NUM_LINES = 9,
   parameter int DLY_W     = 8,
   parameter int ADDR_W    = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 enable,
   input  logic [NUM_LINES-1:0] line_in,
   output logic [NUM_LINES-1:0] line_out,
   output logic [NUM_LINES-1:0] busy,
   rfp_gpo_sequencer_if.slave   cfg
);
   logic [NUM_LINES-1:0] s1, s2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= line_in;
         s2 <= s1;
      end
   end

   // Out-of-range addresses never match any lane index, so they are dropped.
   for (genvar i = 0; i < NUM_LINES; i++) begin : g_lane
      rfp_gpo_seq_lane #(.DLY_W(DLY_W)) u_lane (
         .clk      (clk),
         .rstn     (rstn),
         .enable   (enable),
         .s2       (s2[i]),
         .wr       (cfg.cfg_wr && (cfg.cfg_addr == ADDR_W'(i))),
         .on_dly   (cfg.cfg_on_dly),
         .off_dly  (cfg.cfg_off_dly),
         .inv      (cfg.cfg_inv),
         .line_out (line_out[i]),
         .busy     (busy[i])
      );
   end
endmodule

// File: tb/tb_rfp_gpo_sequencer.sv
// Directed bench for rfp_gpo_sequencer: a cycle table for delays, inversion
// and bad-address writes, plus sequences for glitch, enable drop and async reset.
module tb_rfp_gpo_sequencer;
   localparam int N = 9;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         enable = 1'b0;
   logic [N-1:0] line_in = '0;
   logic [N-1:0] line_out, busy;
   int           errors = 0;
   int           checks = 0;

   rfp_gpo_sequencer_if #(.ADDR_W(4), .DLY_W(8)) cfg_if ();

   rfp_gpo_sequencer #(.NUM_LINES(N), .DLY_W(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .enable   (enable),
      .line_in  (line_in),
      .line_out (line_out),
      .busy     (busy),
      .cfg      (cfg_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] li;
      logic         wr;
      logic [3:0]   a;
      logic [7:0]   on;
      logic [7:0]   off;
      logic         inv;
      logic [N-1:0] eo;
      logic [N-1:0] eb;
   } vec_t;

   vec_t tbl [27];

   function automatic vec_t v(input logic [N-1:0] li, input logic wr, input logic [3:0] a,
                              input logic [7:0] on, input logic [7:0] off, input logic inv,
                              input logic [N-1:0] eo, input logic [N-1:0] eb);
      vec_t r;
      r.li = li; r.wr = wr; r.a = a; r.on = on; r.off = off; r.inv = inv; r.eo = eo; r.eb = eb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_set(input logic wr, input logic [3:0] a, input logic [7:0] on,
                          input logic [7:0] off, input logic inv);
      cfg_if.cfg_wr      = wr;
      cfg_if.cfg_addr    = a;
      cfg_if.cfg_on_dly  = on;
      cfg_if.cfg_off_dly = off;
      cfg_if.cfg_inv     = inv;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] on, input logic [7:0] off,
                            input logic inv);
      cfg_set(1'b1, a, on, off, inv);
      tick();
      cfg_set(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // row k: inputs driven before edge k, outputs checked after edge k
      tbl[0]  = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h000, 9'h000);
      tbl[1]  = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h000, 9'h000);
      tbl[2]  = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h000);
      tbl[3]  = v(9'h001, 1, 4'd3,  8'd5, 8'd3, 0, 9'h001, 9'h000);
      tbl[4]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h000);
      tbl[5]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h000);
      tbl[6]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h008);
      tbl[7]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h008);
      tbl[8]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h008);
      tbl[9]  = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h008);
      tbl[10] = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h008);
      tbl[11] = v(9'h009, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h000);
      tbl[12] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h000);
      tbl[13] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h000);
      tbl[14] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h008);
      tbl[15] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h008);
      tbl[16] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h009, 9'h008);
      tbl[17] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h001, 9'h000);
      tbl[18] = v(9'h001, 1, 4'd8,  8'd0, 8'd0, 1, 9'h001, 9'h000);
      tbl[19] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h101, 9'h000);
      tbl[20] = v(9'h001, 1, 4'd12, 8'd7, 8'd7, 1, 9'h101, 9'h000);
      tbl[21] = v(9'h011, 0, 4'd0,  8'd0, 8'd0, 0, 9'h101, 9'h000);
      tbl[22] = v(9'h011, 0, 4'd0,  8'd0, 8'd0, 0, 9'h101, 9'h000);
      tbl[23] = v(9'h011, 0, 4'd0,  8'd0, 8'd0, 0, 9'h111, 9'h000);
      tbl[24] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h111, 9'h000);
      tbl[25] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h111, 9'h000);
      tbl[26] = v(9'h001, 0, 4'd0,  8'd0, 8'd0, 0, 9'h101, 9'h000);

      cfg_set(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
      enable = 1'b1;

      // Held in reset: inputs toggling must not reach the outputs
      for (int k = 0; k < 3; k++) begin
         line_in = (k % 2 == 0) ? 9'h1FF : 9'h0AA;
         tick();
         chk("reset_out", line_out, 9'h000);
         chk("reset_busy", busy, 9'h000);
      end
      line_in = '0;
      tick();
      #3 rstn = 1'b1;
      @(negedge clk);
      #2;
      // Align to the post-edge drive point used by the table loop
      @(posedge clk);
      #1;

      for (int k = 0; k < 27; k++) begin
         line_in = tbl[k].li;
         cfg_set(tbl[k].wr, tbl[k].a, tbl[k].on, tbl[k].off, tbl[k].inv);
         tick();
         chk($sformatf("row%0d_out", k), line_out, tbl[k].eo);
         chk($sformatf("row%0d_busy", k), busy, tbl[k].eb);
      end
      cfg_set(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);

      // Glitch on line 2: short high then short low pulses are swallowed
      cfg_write(4'd2, 8'd10, 8'd10, 1'b0);
      for (int k = 0; k < 10; k++) begin
         line_in = 9'h001 | ((k < 4) ? 9'h004 : 9'h000);
         tick();
         chk("glitch_hi_out", line_out, 9'h101);
         chk("glitch_hi_busy", busy, (k >= 2 && k <= 5) ? 9'h004 : 9'h000);
      end
      for (int k = 0; k <= 12; k++) begin
         line_in = 9'h005;
         tick();
         if (k == 11 || k == 12) chk("line2_rise_out", line_out, (k == 12) ? 9'h105 : 9'h101);
         if (k == 1 || k == 2 || k == 12) chk("line2_rise_busy", busy, (k == 2) ? 9'h004 : 9'h000);
      end
      for (int k = 0; k < 10; k++) begin
         line_in = 9'h001 | ((k < 4) ? 9'h000 : 9'h004);
         tick();
         chk("glitch_lo_out", line_out, 9'h105);
         chk("glitch_lo_busy", busy, (k >= 2 && k <= 5) ? 9'h004 : 9'h000);
      end
      line_in = 9'h001;
      for (int k = 0; k < 13; k++) tick();
      chk("line2_fall_out", line_out, 9'h101);

      // Enable drop while line 1 is pending its 20-cycle rise
      cfg_write(4'd1, 8'd20, 8'd0, 1'b0);
      line_in = 9'h003;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("en_pend_busy", busy, (k >= 2) ? 9'h002 : 9'h000);
      end
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("en_off_out", line_out, 9'h100);
         chk("en_off_busy", busy, 9'h000);
      end
      enable = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 0 || k >= 19) begin
            chk("reen_out", line_out, (k == 20) ? 9'h103 : 9'h101);
            chk("reen_busy", busy, (k < 20) ? 9'h002 : 9'h000);
         end
      end

      // Async reset while line 4 is in PEND_LOW
      cfg_write(4'd4, 8'd0, 8'd10, 1'b0);
      line_in = 9'h013;
      for (int k = 0; k < 3; k++) tick();
      chk("l4_high_out", line_out, 9'h113);
      line_in = 9'h003;
      for (int k = 0; k < 4; k++) tick();
      chk("l4_pend_out", line_out, 9'h113);
      chk("l4_pend_busy", busy, 9'h010);
      #2 rstn = 1'b0;
      #1;
      chk("arst_out", line_out, 9'h000);
      chk("arst_busy", busy, 9'h000);
      line_in = 9'h010;
      #1 rstn = 1'b1;
      tick();
      tick();
      chk("post_rst_e1_out", line_out, 9'h000);
      tick();
      chk("post_rst_e2_out", line_out, 9'h010);
      chk("post_rst_e2_busy", busy, 9'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rfp_gpo_sequencer.md
Name: rfp_gpo_sequencer

Overview:
- Per-line timing shaper between the GPO line-matrix outputs and the RF front-end GPO pins (rfp_gpo_0..3, 9 lines total).
- Synchronises each routed line into the fabric clock domain.
- Applies programmable turn-on/turn-off delays and optional polarity inversion per line, so T/R switches, LNAs and PAs can be sequenced relative to AD9361 GPO transitions.
- An input transition that reverts before its delay expires is suppressed.

Parameters:
NUM_LINES, 9, number of sequenced lines.
DLY_W, 8, delay counter width; max delay 2^DLY_W-1 cycles.
ADDR_W, 4, cfg_addr width; must satisfy 2^ADDR_W >= NUM_LINES.

Ports:
clk  in  1  fabric clock; all logic rising-edge.
rstn  in  1  asynchronous active-low reset.
enable  in  1  global enable; 0 forces all outputs to their idle level.
line_in  in  NUM_LINES  routed GPO lines from line matrix; asynchronous to clk.
line_out  out  NUM_LINES  registered sequenced lines to rfp_gpo pins.
busy  out  NUM_LINES  1 while the line has a pending (counting) transition.
cfg_wr  in  1  single-cycle config write strobe.
cfg_addr  in  ADDR_W  line index for the write.
cfg_on_dly  in  DLY_W  rise delay in cycles.
cfg_off_dly  in  DLY_W  fall delay in cycles.
cfg_inv  in  1  output polarity invert.

Behaviour:
- Reset (rstn=0, async): sync flops 0; per-line state LOW; counters 0; on/off delays 0; inv 0; line_out 0; busy 0. Release is synchronous in effect: first state update on the first clk edge after rstn high.
- Sync: 2-flop synchroniser per line; s2 is the synchronised value.
- Per-line FSM, states LOW, PEND_HIGH, HIGH, PEND_LOW; state variable lvl is 1 in HIGH/PEND_LOW, else 0.
  - LOW, s2=1: if on_dly=0 go HIGH; else load cnt=on_dly, go PEND_HIGH.
  - PEND_HIGH, s2=0: go LOW (cancel; no output change).
  - PEND_HIGH, s2=1: if cnt=1 go HIGH; else cnt--.
  - HIGH, s2=0: if off_dly=0 go LOW; else load cnt=off_dly, go PEND_LOW.
  - PEND_LOW, s2=1: go HIGH (cancel).
  - PEND_LOW, s2=0: if cnt=1 go LOW; else cnt--.
- line_out[i] = registered (lvl_next ^ inv[i]).
  - busy[i] = registered (state_next is PEND_*).
  - Both update on the same edge as the state.
- Latency: raw line_in stable high before edge E0 -> line_out changes after edge E0+2+on_dly. Falling transitions use off_dly the same way.
- Glitch rule: a raw pulse shorter than the applicable delay (measured at s2) never reaches line_out.
- Config:
  - cfg_wr with cfg_addr < NUM_LINES writes on/off/inv for that line at that edge.
  - cfg_addr >= NUM_LINES is ignored; no line changes.
  - A delay load on the same edge as a write uses the old delay value.
  - A running cnt is never reloaded by a write.
  - An inv write takes effect on line_out the next edge: line_out becomes lvl ^ new inv.
- enable=0:
  - All FSMs go to LOW, counters clear, busy=0, line_out[i]=inv[i] from the next edge.
  - Sync flops keep running; config writes are still accepted.
  - On re-enable, a line with s2=1 starts a fresh on-delay.
- Async reset mid-PEND: outputs go to 0 immediately; no pending transition survives.
- NUM_LINES lines are fully independent; simultaneous events on different lines do not interact.

Test Plan:
- Reset: hold rstn=0, toggle line_in -> line_out=0, busy=0. Release; all delays 0; raise line_in[0] before edge E0 -> line_out[0]=1 after E0+2, busy[0] stays 0.
- Delays: write line 3 on=5 off=3; raise line_in[3] before E0 -> busy[3]=1 from E0+2 to E0+6, line_out[3]=1 after E0+7. Drop line_in[3] before E1 -> line_out[3]=0 after E1+5.
- Glitch: line 2 on=10; 4-cycle high pulse on line_in[2] -> line_out[2] stays 0; busy[2] asserts then clears.
- Invert and bad address: write line 8 inv=1 -> line_out[8]=1 next edge with line_in[8]=0. Write cfg_addr=12 -> no line's config changes (verify by delays).
- Enable drop mid-pend: line 1 on=20, raise line_in[1], deassert enable after 5 cycles -> busy[1]=0, line_out[1]=inv. Re-enable with line_in[1]=1 -> line_out[1]=1 exactly 21 cycles later.
- Async reset mid-pend: assert rstn=0 between clock edges while line 4 is in PEND_LOW -> line_out[4]=0 and busy[4]=0 immediately. After release, config shows defaults (delay 0).
